// File: rtl/sgpr_wr_port_arbiter_pkg.sv
// Shared SGPR write-port definitions: port count, select width, default
// lock length and the types used by the write-port arbiter and its picker.
package sgpr_pkg;

   localparam int SGPR_NUM_WR_PORTS   = 8;
   localparam int SGPR_WR_SEL_WIDTH   = 16;
   localparam int SGPR_WR_MAX_LOCK    = 4;
   localparam int SGPR_PTR_WIDTH      = 3;
   localparam int SGPR_LOCK_CNT_WIDTH = 4;

   typedef logic [SGPR_WR_SEL_WIDTH-1:0] sgpr_wr_sel_t;
   typedef logic [SGPR_NUM_WR_PORTS-1:0] sgpr_port_mask_t;
   typedef logic [SGPR_PTR_WIDTH-1:0]    sgpr_port_idx_t;
   typedef logic [SGPR_LOCK_CNT_WIDTH-1:0] sgpr_lock_cnt_t;

   // What the arbiter decided to do with the write port for the next cycle
   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_LOCKED,
      ARB_STALL
   } arb_decision_t;

endpackage

// File: rtl/sgpr_wr_port_arbiter_pick.sv
// Round-robin priority picker for eight requesters: finds the first set bit
// of the eligible mask starting at the pointer and wrapping 7 -> 0.
module rr_prio_pick8
   import sgpr_pkg::*;
(
   input  sgpr_port_mask_t eligMask_i,
   input  sgpr_port_idx_t  prioPtr_i,
   output sgpr_port_mask_t winOnehot_o,
   output sgpr_port_idx_t  winIdx_o,
   output logic            winValid_o
);

   sgpr_port_idx_t scanIdx;
   logic           found;

   // Scan the mask in rotated order so the pointer position has top priority
   always_comb begin
      winOnehot_o = '0;
      winIdx_o    = '0;
      found       = 1'b0;
      scanIdx     = '0;
      for (int i = 0; i < SGPR_NUM_WR_PORTS; i++) begin
         scanIdx = prioPtr_i + SGPR_PTR_WIDTH'(i);
         if (!found && eligMask_i[scanIdx]) begin
            found                = 1'b1;
            winIdx_o             = scanIdx;
            winOnehot_o          = '0;
            winOnehot_o[scanIdx] = 1'b1;
         end
      end
      winValid_o = found;
   end

endmodule

// File: rtl/sgpr_wr_port_arbiter.sv
// Round-robin arbiter for the single SGPR write port. Holds the priority
// pointer, the lock-beat counter and the registered one-hot select/grant.
module sgpr_wr_port_arbiter
   import sgpr_pkg::*;
#(
   parameter int NUM_PORTS = SGPR_NUM_WR_PORTS,
   parameter int SEL_WIDTH = SGPR_WR_SEL_WIDTH,
   parameter int MAX_LOCK  = SGPR_WR_MAX_LOCK
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PORTS-1:0] port_req,
   input  logic [NUM_PORTS-1:0] port_req_lock,
   input  logic                 wr_stall,
   output logic [SEL_WIDTH-1:0] wr_port_select,
   output logic [NUM_PORTS-1:0] port_grant,
   output logic                 arb_busy
);

   localparam sgpr_lock_cnt_t LOCK_LIMIT = SGPR_LOCK_CNT_WIDTH'(MAX_LOCK - 1);

   sgpr_port_mask_t grant_q,     grant_d;
   sgpr_port_mask_t lastGrant_q, lastGrant_d;
   sgpr_port_idx_t  prioPtr_q,   prioPtr_d;
   sgpr_lock_cnt_t  lockCnt_q,   lockCnt_d;
   logic            busy_q,      busy_d;

   sgpr_port_mask_t eligMask;
   sgpr_port_mask_t winOnehot;
   sgpr_port_idx_t  winIdx;
   logic            winValid;
   logic            lockHit;
   arb_decision_t   decision;

   // lastGrant_q tracks the most recent real grant and survives stall beats,
   // so a lock can resume after a stall and that port sits out one round
   assign eligMask = port_req & ~lastGrant_q;
   assign lockHit  = (|(lastGrant_q & port_req & port_req_lock)) && (lockCnt_q < LOCK_LIMIT);

   rr_prio_pick8 u_pick (
      .eligMask_i  (eligMask),
      .prioPtr_i   (prioPtr_q),
      .winOnehot_o (winOnehot),
      .winIdx_o    (winIdx),
      .winValid_o  (winValid)
   );

   // Stall beats everything, then an active lock, then a fresh round-robin pick
   always_comb begin
      decision = ARB_IDLE;
      if (wr_stall) begin
         decision = ARB_STALL;
      end else if (lockHit) begin
         decision = ARB_LOCKED;
      end else if (winValid) begin
         decision = ARB_GRANT;
      end
   end

   // Next grant, pointer, lock counter and busy flag for each decision
   always_comb begin
      grant_d     = '0;
      lastGrant_d = lastGrant_q;
      prioPtr_d   = prioPtr_q;
      lockCnt_d   = lockCnt_q;
      busy_d      = 1'b0;
      case (decision)
         ARB_STALL: begin
            grant_d = '0;
         end
         ARB_LOCKED: begin
            grant_d   = lastGrant_q;
            lockCnt_d = lockCnt_q + 1'b1;
            busy_d    = 1'b1;
         end
         ARB_GRANT: begin
            grant_d     = winOnehot;
            lastGrant_d = winOnehot;
            prioPtr_d   = winIdx + 1'b1;
            lockCnt_d   = '0;
         end
         default: begin
            lastGrant_d = '0;
            lockCnt_d   = '0;
         end
      endcase
   end

   // Arbiter state and registered outputs, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q     <= '0;
         lastGrant_q <= '0;
         prioPtr_q   <= '0;
         lockCnt_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         prioPtr_q   <= prioPtr_d;
         lockCnt_q   <= lockCnt_d;
         busy_q      <= busy_d;
      end
   end

   assign port_grant     = grant_q;
   assign wr_port_select = {{(SEL_WIDTH-NUM_PORTS){1'b0}}, grant_q};
   assign arb_busy       = busy_q;

endmodule

// File: tb/tb_sgpr_wr_port_arbiter.sv
// Directed self-checking bench for the SGPR write-port arbiter.
module tb_sgpr_wr_port_arbiter;
   import sgpr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  portReq;
   logic [7:0]  portReqLock;
   logic        wrStall;
   logic [15:0] wrPortSelect;
   logic [7:0]  portGrant;
   logic        arbBusy;

   int assertCount = 0;
   int failCount   = 0;

   // 10-unit clock period
   always #5 clk = ~clk;

   sgpr_wr_port_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .port_req       (portReq),
      .port_req_lock  (portReqLock),
      .wr_stall       (wrStall),
      .wr_port_select (wrPortSelect),
      .port_grant     (portGrant),
      .arb_busy       (arbBusy)
   );

   // The select must be one-hot or zero, upper bits clear, and mirror the grant
   always @(negedge clk) begin
      assertCount++;
      assert ($onehot0(wrPortSelect) && (wrPortSelect[15:8] === 8'h00) &&
              (portGrant === wrPortSelect[7:0]))
      else begin
         failCount++;
         $error("[TB] FAIL onehot: observed select %h grant %h expected onehot0 with grant == select[7:0]",
                wrPortSelect, portGrant);
      end
   end

   // Advance one clock and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive all arbiter inputs at once
   task automatic applyStimulus(input logic [7:0] req, input logic [7:0] lock, input logic stall);
      portReq     = req;
      portReqLock = lock;
      wrStall     = stall;
   endtask

   // Compare grant, select and busy against hand-computed values
   task automatic checkOutput(input string tag, input logic [7:0] expGrant, input logic expBusy);
      logic [15:0] expSel;
      expSel = {8'h00, expGrant};
      assertCount++;
      assert (portGrant === expGrant)
      else begin
         failCount++;
         $error("[TB] FAIL %s grant: observed %h expected %h", tag, portGrant, expGrant);
      end
      assertCount++;
      assert (wrPortSelect === expSel)
      else begin
         failCount++;
         $error("[TB] FAIL %s select: observed %h expected %h", tag, wrPortSelect, expSel);
      end
      assertCount++;
      assert (arbBusy === expBusy)
      else begin
         failCount++;
         $error("[TB] FAIL %s busy: observed %b expected %b", tag, arbBusy, expBusy);
      end
   endtask

   // Hold reset across an edge with inputs quiet, then release
   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(8'h00, 8'h00, 1'b0);
      tick();
      rst_n = 1'b1;
   endtask

   // Directed sequence of scenarios
   initial begin
      logic [7:0] expGrant;
      int waitCnt;
      int maxWait;
      int p0Grants;

      rst_n = 1'b0;
      applyStimulus(8'h00, 8'h00, 1'b0);
      tick();
      checkOutput("reset", 8'h00, 1'b0);
      tick();
      rst_n = 1'b1;

      $display("[TB] single request");
      applyStimulus(8'h04, 8'h00, 1'b0);
      tick();
      checkOutput("single_grant", 8'h04, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      tick();
      checkOutput("single_release", 8'h00, 1'b0);

      $display("[TB] all ports requesting without lock");
      doReset();
      applyStimulus(8'hFF, 8'h00, 1'b0);
      for (int i = 0; i < 9; i++) begin
         tick();
         expGrant = 8'(1 << (i % 8));
         checkOutput($sformatf("rr_%0d", i), expGrant, 1'b0);
      end
      applyStimulus(8'h00, 8'h00, 1'b0);
      tick();
      checkOutput("rr_idle", 8'h00, 1'b0);

      $display("[TB] lock burst on port 5 with port 2 waiting");
      doReset();
      applyStimulus(8'h20, 8'h20, 1'b0);
      tick();
      checkOutput("lock5_b1", 8'h20, 1'b0);
      applyStimulus(8'h24, 8'h20, 1'b0);
      for (int b = 2; b <= 4; b++) begin
         tick();
         checkOutput($sformatf("lock5_b%0d", b), 8'h20, 1'b1);
      end
      tick();
      checkOutput("lock5_then_p2", 8'h04, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      tick();
      checkOutput("lock5_idle", 8'h00, 1'b0);

      $display("[TB] stall during port 3 lock");
      doReset();
      applyStimulus(8'h08, 8'h08, 1'b0);
      tick();
      checkOutput("lock3_b1", 8'h08, 1'b0);
      tick();
      checkOutput("lock3_b2", 8'h08, 1'b1);
      applyStimulus(8'h08, 8'h08, 1'b1);
      tick();
      checkOutput("stall_1", 8'h00, 1'b0);
      tick();
      checkOutput("stall_2", 8'h00, 1'b0);
      applyStimulus(8'h08, 8'h08, 1'b0);
      tick();
      checkOutput("lock3_b3", 8'h08, 1'b1);
      tick();
      checkOutput("lock3_b4", 8'h08, 1'b1);
      tick();
      checkOutput("lock3_done", 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);

      $display("[TB] reset in the middle of a port 6 lock");
      doReset();
      applyStimulus(8'h40, 8'h40, 1'b0);
      tick();
      checkOutput("lock6_b1", 8'h40, 1'b0);
      tick();
      checkOutput("lock6_b2", 8'h40, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 8'h00, 1'b0);
      applyStimulus(8'hC1, 8'h00, 1'b0);
      #2;
      rst_n = 1'b1;
      tick();
      checkOutput("post_reset_first", 8'h01, 1'b0);

      $display("[TB] pointer wrap-around");
      applyStimulus(8'h40, 8'h00, 1'b0);
      tick();
      checkOutput("wrap_p6", 8'h40, 1'b0);
      applyStimulus(8'h81, 8'h00, 1'b0);
      tick();
      checkOutput("wrap_p7", 8'h80, 1'b0);
      tick();
      checkOutput("wrap_p0", 8'h01, 1'b0);
      tick();
      checkOutput("wrap_p7_again", 8'h80, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      tick();
      checkOutput("wrap_idle", 8'h00, 1'b0);

      $display("[TB] worst-case wait with every port locking");
      doReset();
      applyStimulus(8'hFF, 8'hFF, 1'b0);
      waitCnt  = 0;
      maxWait  = 0;
      p0Grants = 0;
      for (int c = 0; c < 70; c++) begin
         tick();
         if (portGrant[0]) begin
            p0Grants++;
            waitCnt = 0;
         end else begin
            waitCnt++;
            if (waitCnt > maxWait) maxWait = waitCnt;
         end
      end
      assertCount++;
      assert (maxWait == 7 * SGPR_WR_MAX_LOCK)
      else begin
         failCount++;
         $error("[TB] FAIL worst_wait: observed %0d expected %0d", maxWait, 7 * SGPR_WR_MAX_LOCK);
      end
      assertCount++;
      assert (p0Grants == 12)
      else begin
         failCount++;
         $error("[TB] FAIL port0_beats: observed %0d expected %0d", p0Grants, 12);
      end
      applyStimulus(8'h00, 8'h00, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/sgpr_wr_port_arbiter.md
# sgpr_wr_port_arbiter

Round-robin arbiter that shares the single SGPR write port among eight write requesters (ALU, LSU return, branch/PC, etc.). Each cycle it picks at most one requesting port and drives the registered one-hot `wr_port_select` consumed by the SGPR write-port mux. It also returns a matching grant to the winner. Optional short locked bursts are supported for multi-dword returns, and a stall input freezes the write port.

## Interface
Parameters:
- `NUM_PORTS`, 8: number of requesters; fixed at 8 to match the mux.
- `SEL_WIDTH`, 16: width of `wr_port_select`. Bits above `NUM_PORTS-1` are always 0.
- `MAX_LOCK`, 4: maximum consecutive beats granted to one locked port. Legal range 1–15.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `port_req`, input, 8: bit i is high while port i has a write pending. It is held until granted.
- `port_req_lock`, input, 8: bit i requests that port i keep the grant for its next beat. Only meaningful together with `port_req[i]`.
- `wr_stall`, input, 1: the SGPR file cannot accept a write next cycle.
- `wr_port_select`, output, 16: registered one-hot select to the mux, or 16'h0000 when idle.
- `port_grant`, output, 8: registered, equal to `wr_port_select[7:0]`. Port i's write is consumed in the cycle its grant bit is high.
- `arb_busy`, output, 1: registered. High while a lock is in force.

## Operation
- Reset state:
  - `wr_port_select` = 16'h0000, `port_grant` = 0, `arb_busy` = 0.
  - Priority pointer = 0, so port 0 has highest priority.
  - Lock counter = 0.
- Eligibility mask: the port granted in the current cycle is excluded from this cycle's arbitration unless it holds the lock. This prevents a double grant while the requester drops `port_req` after its grant beat.
- Arbitration, evaluated each cycle and registered at the next edge:
  - If `wr_stall` = 1: next select = 0. Pointer and lock counter hold.
  - Else if a lock is held by port g (see below): next select = port g.
  - Else: scan eligible `port_req` from the pointer upward, wrapping 7→0. The first hit wins.
  - If there are no eligible requests: next select = 0.
- Pointer update: after a non-locked grant to port i, pointer = (i+1) mod 8. The pointer does not move while a lock is held or while idle.
- Lock rule: lock is held by port g when all of the following are true in the current cycle:
  - `port_grant[g]`
  - `port_req[g]`
  - `port_req_lock[g]`
  - lock counter < `MAX_LOCK`-1
- Lock counter:
  - Increments on each locked re-grant.
  - Clears to 0 on any non-locked grant or on idle.
  - When the counter reaches `MAX_LOCK`-1, that beat's lock request is ignored. Port g becomes ineligible for one arbitration and the pointer advances past g.
- `arb_busy` = 1 in the cycle after a lock decision, i.e. while the locked grant is visible.
- Onehot invariant: `wr_port_select` has at most one bit set and bits [15:8] are always 0. Verification must assert this every cycle.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous). Pending requests are re-arbitrated from pointer 0 after `rst_n` rises.

## Timing
- Latency: a request seen at edge t is granted at edge t+1 at the earliest, i.e. one cycle from request to `port_grant`.
- Grant and select are high in the same cycle. The requester presents `wr_en`/addr/data/mask in that cycle.
- Back-to-back:
  - Different ports can be granted on consecutive cycles.
  - The same port without lock cannot be granted on consecutive cycles; the minimum gap is 1 cycle.
- Stall: `wr_stall` high during cycle t forces select = 0 in cycle t+1. Arbitration resumes with the same pointer and lock state in the cycle after `wr_stall` falls.
- Lock with stall: a stall beat does not consume or clear the lock counter.
- Worst-case wait for a continuously requesting port is 7 grants × `MAX_LOCK` beats plus stall cycles. This bound must be proven in formal or sim.

## Structure
- Shared package `sgpr_pkg`:
  - `SGPR_NUM_WR_PORTS` = 8
  - `SGPR_WR_SEL_WIDTH` = 16
  - `SGPR_WR_MAX_LOCK` default
  - the `sgpr_wr_sel_t` 16-bit typedef
- Sub-module `rr_prio_pick8`: combinational rotate / find-first / unrotate picker.
  - Inputs: eligible mask and pointer.
  - Outputs: one-hot winner and its index.
- Top level holds the pointer, lock counter, masking logic, and output registers.

## Test plan
- Reset then single request: `port_req` = 8'h04 from cycle 2.
  - `port_grant` = 8'h04 and `wr_port_select` = 16'h0004 in cycle 3.
  - Requester drops req; select returns to 0 in cycle 4.
- All ports continuously requesting, no lock:
  - Grants cycle 0x01, 0x02, 0x04 … 0x80, 0x01.
  - No port is granted twice in a row.
  - Onehot assertion holds throughout.
- Lock burst on port 5 with `MAX_LOCK` = 4 and port 2 also requesting:
  - Port 5 granted for 4 consecutive beats, `arb_busy` high on beats 2–4.
  - Port 2 granted on the 5th beat.
- `wr_stall` pulses for 2 cycles during a port-3 lock:
  - Select = 0 for exactly those 2 cycles.
  - Port 3 then resumes with the remaining lock beats; total beats still 4.
- `rst_n` asserted mid-lock on port 6:
  - Outputs go to 0 asynchronously, before the next edge.
  - After release with `port_req` = 8'hC1, the first grant is port 0.
- Wrap-around: pointer at 7, `port_req` = 8'h81 → grant port 7, then port 0, then port 7.
